// File: rtl/ps2_line_interpreter.sv
// Parses one latched 32-character text line per start event and applies
// velocity / angle / fire commands to held outputs.
module ps2_line_interpreter (
    input  logic         clock,
    input  logic         reset,
    input  logic [255:0] input_line,
    input  logic         line_ready,
    output logic [31:0]  velocity,
    output logic [31:0]  angle,
    output logic         fire
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_SKIP,
        ST_DIGITS,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        TGT_VEL,
        TGT_ANG,
        TGT_FIRE
    } target_t;

    state_t        state_q, state_d;
    target_t       target_q, target_d;
    logic [255:0]  line_buf_q, line_buf_d;
    logic [5:0]    index_q, index_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   velocity_q, velocity_d;
    logic [31:0]   angle_q, angle_d;
    logic          fire_q, fire_d;
    logic          ready_prev_q;

    logic [7:0]    line_chars [0:31];
    logic [7:0]    cur_char;
    logic [7:0]    folded_char;
    logic          is_space;
    logic          is_digit;
    logic          is_nul;
    logic [31:0]   digit_val;
    logic [31:0]   acc_times10;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi = gi + 1) begin : g_chars
            assign line_chars[gi] = line_buf_q[255 - 8*gi -: 8];
        end
    endgenerate

    // Running off the end of the buffer reads as a terminator.
    assign cur_char    = index_q[5] ? 8'h00 : line_chars[index_q[4:0]];
    assign folded_char = cur_char | 8'h20;
    assign is_space    = (cur_char == 8'h20);
    assign is_nul      = (cur_char == 8'h00);
    assign is_digit    = (cur_char >= 8'h30) && (cur_char <= 8'h39);
    assign digit_val   = {28'd0, cur_char[3:0]};
    assign acc_times10 = (acc_q << 3) + (acc_q << 1) + digit_val;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        line_buf_d = line_buf_q;
        index_d    = index_q;
        acc_d      = acc_q;
        velocity_d = velocity_q;
        angle_d    = angle_q;
        fire_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (line_ready && !ready_prev_q) begin
                    line_buf_d = input_line;
                    index_d    = 6'd0;
                    acc_d      = 32'd0;
                    state_d    = ST_CMD;
                end
            end
            ST_CMD: begin
                index_d = index_q + 6'd1;
                if (is_space) begin
                    state_d = ST_CMD;
                end else if (folded_char == 8'h76) begin
                    target_d = TGT_VEL;
                    state_d  = ST_SKIP;
                end else if (folded_char == 8'h61) begin
                    target_d = TGT_ANG;
                    state_d  = ST_SKIP;
                end else if (folded_char == 8'h66) begin
                    target_d = TGT_FIRE;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SKIP: begin
                index_d = index_q + 6'd1;
                if (is_space) begin
                    state_d = ST_SKIP;
                end else if (is_digit) begin
                    acc_d   = digit_val;
                    state_d = ST_DIGITS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIGITS: begin
                index_d = index_q + 6'd1;
                if (is_digit) begin
                    acc_d = acc_times10;
                end else if (is_nul || is_space) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                case (target_q)
                    TGT_VEL:  velocity_d = acc_q;
                    TGT_ANG:  if (acc_q <= 32'd359) angle_d = acc_q;
                    TGT_FIRE: fire_d = 1'b1;
                    default:  fire_d = 1'b0;
                endcase
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            target_q     <= TGT_VEL;
            line_buf_q   <= '0;
            index_q      <= '0;
            acc_q        <= '0;
            velocity_q   <= '0;
            angle_q      <= '0;
            fire_q       <= 1'b0;
            ready_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            line_buf_q   <= line_buf_d;
            index_q      <= index_d;
            acc_q        <= acc_d;
            velocity_q   <= velocity_d;
            angle_q      <= angle_d;
            fire_q       <= fire_d;
            ready_prev_q <= line_ready;
        end
    end

    assign velocity = velocity_q;
    assign angle    = angle_q;
    assign fire     = fire_q;

endmodule

// File: tb/tb_ps2_line_interpreter.sv
// Scoreboard bench: each line pushes its expected output event (cycle and values);
// the monitor pops one entry whenever the outputs change or fire pulses.
module tb_ps2_line_interpreter;

    logic         clock = 1'b0;
    logic         reset;
    logic [255:0] input_line;
    logic         line_ready;
    logic [31:0]  velocity;
    logic [31:0]  angle;
    logic         fire;

    typedef struct {
        int          cyc;
        logic [31:0] v;
        logic [31:0] a;
        logic        f;
    } exp_t;

    exp_t        exp_q [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic [31:0] prev_v;
    logic [31:0] prev_a;

    ps2_line_interpreter dut (
        .clock      (clock),
        .reset      (reset),
        .input_line (input_line),
        .line_ready (line_ready),
        .velocity   (velocity),
        .angle      (angle),
        .fire       (fire)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [255:0] mk(input string s);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < s.len() && k < 32; k++) r[255 - 8*k -: 8] = s[k];
        return r;
    endfunction

    // Monitor: any output change or fire pulse is one transaction.
    always @(negedge clock) begin
        if (mon_en) begin
            if (velocity !== prev_v || angle !== prev_a || fire !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d vel=%0d ang=%0d fire=%b, required no event",
                             cyc, velocity, angle, fire);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.v !== velocity || e.a !== angle || e.f !== fire) begin
                        errors++;
                        $display("FAIL event got cyc=%0d vel=%0d ang=%0d fire=%b, required cyc=%0d vel=%0d ang=%0d fire=%b",
                                 cyc, velocity, angle, fire, e.cyc, e.v, e.a, e.f);
                    end else begin
                        $display("event ok cyc=%0d vel=%0d ang=%0d fire=%b", cyc, velocity, angle, fire);
                    end
                end
            end
            prev_v = velocity;
            prev_a = angle;
        end
    end

    task automatic check_hold(input string name, input logic [31:0] ev, input logic [31:0] ea);
        checks++;
        if (velocity !== ev || angle !== ea || fire !== 1'b0) begin
            errors++;
            $display("FAIL %s got vel=%0d ang=%0d fire=%b, required vel=%0d ang=%0d fire=0",
                     name, velocity, angle, fire, ev, ea);
        end else begin
            $display("line '%s' done vel=%0d ang=%0d", name, velocity, angle);
        end
    endtask

    // t < 0: no output event expected; otherwise event at L+2+t.
    task automatic send_line(input string s, input int hold, input int t,
                             input logic [31:0] ev, input logic [31:0] ea, input logic ef);
        int l_edge;
        @(negedge clock);
        input_line = mk(s);
        line_ready = 1'b1;
        @(negedge clock);
        l_edge = cyc;
        if (t >= 0) exp_q.push_back('{l_edge + 2 + t, ev, ea, ef});
        repeat (hold - 1) @(negedge clock);
        line_ready = 1'b0;
        repeat (40) @(negedge clock);
        check_hold(s, ev, ea);
    endtask

    initial begin
        int l_edge;
        reset      = 1'b1;
        line_ready = 1'b0;
        input_line = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_hold("reset", 32'd0, 32'd0);
        prev_v = velocity;
        prev_a = angle;
        mon_en = 1'b1;

        send_line("v 25",  1,  4, 32'd25, 32'd0,   1'b0);
        send_line("A45",   1,  3, 32'd25, 32'd45,  1'b0);
        send_line("a 400", 1, -1, 32'd25, 32'd45,  1'b0);
        send_line("a 359", 1,  5, 32'd25, 32'd359, 1'b0);
        send_line("fire",  1,  0, 32'd25, 32'd359, 1'b1);
        send_line("v 12x", 1, -1, 32'd25, 32'd359, 1'b0);
        send_line("x 5",   1, -1, 32'd25, 32'd359, 1'b0);
        send_line("v",     1, -1, 32'd25, 32'd359, 1'b0);
        send_line("",      1, -1, 32'd25, 32'd359, 1'b0);
        send_line("v 4294967296", 1, 12, 32'd0,        32'd359, 1'b0);
        send_line("v 4294967295", 1, 12, 32'hFFFFFFFF, 32'd359, 1'b0);

        // Reset sampled at L+3 of "v 99": outputs clear, no commit follows.
        @(negedge clock);
        input_line = mk("v 99");
        line_ready = 1'b1;
        @(negedge clock);
        l_edge = cyc;
        line_ready = 1'b0;
        exp_q.push_back('{l_edge + 3, 32'd0, 32'd0, 1'b0});
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check_hold("reset mid-parse", 32'd0, 32'd0);

        send_line("v 7", 1, 3, 32'd7, 32'd0, 1'b0);

        // Second pulse with a different line during a parse is ignored.
        @(negedge clock);
        input_line = mk("v 8");
        line_ready = 1'b1;
        @(negedge clock);
        l_edge = cyc;
        line_ready = 1'b0;
        exp_q.push_back('{l_edge + 5, 32'd8, 32'd0, 1'b0});
        @(negedge clock);
        input_line = mk("v 9");
        line_ready = 1'b1;
        @(negedge clock);
        line_ready = 1'b0;
        repeat (40) @(negedge clock);
        check_hold("busy", 32'd8, 32'd0);

        send_line("a 12", 1, 4, 32'd8, 32'd12, 1'b0);
        send_line("F",   50, 0, 32'd8, 32'd12, 1'b1);
        send_line("v 000000000000000000000000000123", 1, 32, 32'd123, 32'd12, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d outstanding, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
